// File: rtl/display_vram_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the 1bpp display video RAM.
package display_vram_pkg;
  localparam int DISP_COLS = 10;
  localparam int DISP_ROWS = 240;
  localparam int DEPTH     = DISP_COLS * DISP_ROWS;
  localparam int ADDR_W    = 12;
  localparam int FIFO_D    = 4;
  localparam int BLINK_DIV = 12_500_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } clr_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_entry_t;
endpackage

// File: rtl/display_vram_ram.sv
// Simple dual-port word RAM: one byte-masked write port, one registered read port.
// A same-cycle read of the word being written returns the old contents.
module display_vram_ram #(
  parameter int DEPTH  = 2400,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Byte-masked write and registered read share one clocked block so the read sees pre-write data.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we && be[k]) begin
        mem_r[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;
endmodule

// File: rtl/display_vram.sv
// 1bpp video RAM: CPU write FIFO, whole-screen clear engine and blinking cursor overlay,
// all in the pixel-clock domain.
module display_vram
  import display_vram_pkg::*;
#(
  parameter int DEPTH     = display_vram_pkg::DEPTH,
  parameter int ADDR_W    = display_vram_pkg::ADDR_W,
  parameter int BLINK_DIV = display_vram_pkg::BLINK_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        clear_req,
  input  logic [31:0] fill_data,
  output logic        busy,
  output logic        wr_err,
  input  logic [31:0] pointer,
  output logic [31:0] displayData,
  input  logic        cursor_en,
  input  logic [31:0] cursor_addr,
  output logic        cursor
);
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [31:0]       DEPTH_W   = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_D);

  wr_entry_t         fifo_mem_r [FIFO_D];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  clr_state_e        state_r;
  logic              clear_pend_r;
  logic [31:0]       fill_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic              wr_ready_r;
  logic              wr_err_r;
  logic [BLK_W-1:0]  blk_cnt_r;
  logic              phase_r;
  logic              cursor_r;
  logic              ovl_r;
  logic              rd_ok_r;

  logic              push_s;
  logic              pop_s;
  wr_entry_t         head_s;
  logic              head_ok_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  clr_state_e        state_nxt_s;
  logic              pend_nxt_s;
  logic [31:0]       fill_nxt_s;
  logic [ADDR_W-1:0] clr_addr_nxt_s;

  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [31:0]       ram_wdata_s;
  logic [3:0]        ram_be_s;
  logic [31:0]       ram_rdata_s;

  assign push_s    = wr_valid && wr_ready_r;
  assign pop_s     = (cnt_r != CNT_ZERO) && ((state_r == ST_IDLE) || (state_r == ST_DRAIN));
  assign head_s    = fifo_mem_r[rd_ptr_r];
  assign head_ok_s = head_s.addr < DEPTH_W;
  assign cnt_nxt_s = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);

  // Clear sequencer next state: drain queued writes first so they land before the fill.
  always_comb begin
    state_nxt_s    = state_r;
    pend_nxt_s     = clear_pend_r;
    fill_nxt_s     = fill_r;
    clr_addr_nxt_s = clr_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt_s = ST_DRAIN;
          pend_nxt_s  = 1'b1;
          fill_nxt_s  = fill_data;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s    = ST_CLEAR;
          clr_addr_nxt_s = ADDR_W'(0);
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_r == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
          pend_nxt_s  = 1'b0;
        end else begin
          clr_addr_nxt_s = clr_addr_r + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // RAM write port: fill engine owns it while clearing, otherwise the FIFO head; rst blocks writes.
  always_comb begin
    if (state_r == ST_CLEAR) begin
      ram_we_s    = !rst;
      ram_waddr_s = clr_addr_r;
      ram_wdata_s = fill_r;
      ram_be_s    = 4'hF;
    end else begin
      ram_we_s    = pop_s && head_ok_s && !rst;
      ram_waddr_s = head_s.addr[ADDR_W-1:0];
      ram_wdata_s = head_s.data;
      ram_be_s    = head_s.be;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by cnt_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= '{addr: wr_addr, data: wr_data, be: wr_be};
    end
  end

  // Control, status, blink and read-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= PTR_W'(0);
      wr_ptr_r     <= PTR_W'(0);
      cnt_r        <= CNT_ZERO;
      state_r      <= ST_IDLE;
      clear_pend_r <= 1'b0;
      fill_r       <= 32'h0;
      clr_addr_r   <= ADDR_W'(0);
      wr_ready_r   <= 1'b0;
      wr_err_r     <= 1'b0;
      blk_cnt_r    <= BLK_W'(0);
      phase_r      <= 1'b1;
      cursor_r     <= 1'b0;
      ovl_r        <= 1'b0;
      rd_ok_r      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      cnt_r        <= cnt_nxt_s;
      state_r      <= state_nxt_s;
      clear_pend_r <= pend_nxt_s;
      fill_r       <= fill_nxt_s;
      clr_addr_r   <= clr_addr_nxt_s;
      // Ready is precomputed from next-cycle state so the port itself is a flop.
      wr_ready_r   <= (cnt_nxt_s != CNT_FULL) && (state_nxt_s == ST_IDLE) && !pend_nxt_s;
      wr_err_r     <= wr_err_r || (pop_s && !head_ok_s);
      if (blk_cnt_r == BLK_LAST) begin
        blk_cnt_r <= BLK_W'(0);
        phase_r   <= !phase_r;
      end else begin
        blk_cnt_r <= blk_cnt_r + BLK_W'(1);
      end
      cursor_r <= phase_r && cursor_en;
      ovl_r    <= (pointer == cursor_addr) && cursor_en && phase_r;
      rd_ok_r  <= pointer < DEPTH_W;
    end
  end

  display_vram_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .be    (ram_be_s),
    .raddr (pointer[ADDR_W-1:0]),
    .rdata (ram_rdata_s)
  );

  assign displayData = rd_ok_r ? (ram_rdata_s ^ {32{ovl_r}}) : 32'h0;
  assign wr_ready    = wr_ready_r;
  assign busy        = clear_pend_r;
  assign wr_err      = wr_err_r;
  assign cursor      = cursor_r;
endmodule

// File: tb/tb_display_vram.sv
// Self-checking bench for display_vram (DEPTH=16, BLINK_DIV=8): table vectors, hand sequences
// and randomized writes against an array model of the RAM.
module tb_display_vram;
  localparam int TB_DEPTH = 16;
  localparam int TB_BLINK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  wr_be = 4'h0;
  logic        clear_req = 1'b0;
  logic [31:0] fill_data = 32'h0;
  logic        busy;
  logic        wr_err;
  logic [31:0] pointer = 32'h0;
  logic [31:0] displayData;
  logic        cursor_en = 1'b0;
  logic [31:0] cursor_addr = 32'h0;
  logic        cursor;

  display_vram #(.DEPTH(TB_DEPTH), .ADDR_W(4), .BLINK_DIV(TB_BLINK)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .clear_req(clear_req), .fill_data(fill_data),
    .busy(busy), .wr_err(wr_err), .pointer(pointer), .displayData(displayData),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr), .cursor(cursor)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  logic [31:0] model_mem [TB_DEPTH];
  bit model_err = 1'b0;

  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a >= TB_DEPTH) begin
      model_err = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) if (be[k]) model_mem[a][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    wr_addr = a; wr_data = d; wr_be = be; wr_valid = 1'b1;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL write_timeout: wr_ready stayed 0 for addr %h", a);
    end
    tick();
    wr_valid = 1'b0;
    model_write(a, d, be);
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < TB_DEPTH; a++) begin
      pointer = 32'(a);
      tick();
      chk($sformatf("%s[%0d]", nm, a), displayData, model_mem[a]);
    end
  endtask

  task automatic do_clear(input logic [31:0] f, input int exp_busy);
    int n = 0;
    clear_req = 1'b1; fill_data = f;
    tick();
    clear_req = 1'b0;
    while (busy && n < 200) begin
      if (wr_ready !== 1'b0) chk("ready_while_busy", {31'h0, wr_ready}, 32'h0);
      n++;
      tick();
    end
    chk("clear_busy_cycles", 32'(n), 32'(exp_busy));
    chk("ready_after_clear", {31'h0, wr_ready}, 32'h1);
    for (int a = 0; a < TB_DEPTH; a++) model_mem[a] = f;
  endtask

  initial begin
    tbl[0] = '{addr: 32'd5,  data: 32'hDEADBEEF, be: 4'hF,    exp: 32'hDEADBEEF};
    tbl[1] = '{addr: 32'd3,  data: 32'hFFFFFFFF, be: 4'hF,    exp: 32'hFFFFFFFF};
    tbl[2] = '{addr: 32'd3,  data: 32'h00000000, be: 4'b0101, exp: 32'hFF00FF00};
    tbl[3] = '{addr: 32'd0,  data: 32'h12345678, be: 4'b0010, exp: 32'h00005600};
    tbl[4] = '{addr: 32'd15, data: 32'hCAFEF00D, be: 4'b1000, exp: 32'hCA000000};
    tbl[5] = '{addr: 32'd5,  data: 32'h00000000, be: 4'b0001, exp: 32'hDEADBE00};

    // Reset state
    tick(); tick();
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_err", {31'h0, wr_err}, 32'h0);
    chk("rst_displayData", displayData, 32'h0);
    chk("rst_cursor", {31'h0, cursor}, 32'h0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {31'h0, wr_ready}, 32'h1);

    // Clear with an empty FIFO: one drain cycle plus DEPTH fill cycles
    do_clear(32'h0, 1 + TB_DEPTH);
    read_all("clear0");

    // Table vectors: each write then readback once committed
    for (int i = 0; i < 6; i++) begin
      do_write(tbl[i].addr, tbl[i].data, tbl[i].be);
      tick(); tick();
      pointer = tbl[i].addr;
      tick();
      chk($sformatf("vec%0d", i), displayData, tbl[i].exp);
    end

    // Commit latency: push at E0, commit at E1 (collision reads old), new data from E2 sample
    pointer = 32'd7;
    tick();
    begin
      logic [31:0] old_v;
      old_v = model_mem[7];
      do_write(32'd7, 32'h11223344, 4'hF);
      chk("lat_push_edge", displayData, old_v);
      tick();
      chk("lat_commit_edge_old", displayData, old_v);
      tick();
      chk("lat_new_data", displayData, 32'h11223344);
    end

    // Randomized back-to-back writes; pop keeps pace so wr_ready never drops
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, TB_DEPTH + 1));
      if (wr_ready !== 1'b1) chk("stream_ready", {31'h0, wr_ready}, 32'h1);
      do_write(a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick(); tick(); tick();
    read_all("rand");
    chk("rand_wr_err", {31'h0, wr_err}, {31'h0, model_err});
    pointer = 32'd16;          tick(); chk("oob_16", displayData, 32'h0);
    pointer = 32'h0001_0003;   tick(); chk("oob_upper_bits", displayData, 32'h0);

    // Two queued writes then clear: busy for 2 + DEPTH, queued data overwritten
    do_write(32'd1, 32'h01010101, 4'hF);
    wr_addr = 32'd2; wr_data = 32'h02020202; wr_be = 4'hF; wr_valid = 1'b1;
    chk("ready_with_clear", {31'h0, wr_ready}, 32'h1);
    clear_req = 1'b1; fill_data = 32'hA5A5A5A5;
    tick();
    wr_valid = 1'b0; clear_req = 1'b0;
    begin
      int n = 0;
      while (busy && n < 200) begin
        if (wr_ready !== 1'b0) chk("ready_while_drain", {31'h0, wr_ready}, 32'h0);
        n++;
        tick();
      end
      chk("queued_clear_busy", 32'(n), 32'(2 + TB_DEPTH));
    end
    for (int a = 0; a < TB_DEPTH; a++) model_mem[a] = 32'hA5A5A5A5;
    read_all("fillA5");

    // Out-of-range write is dropped and sets sticky wr_err
    do_write(32'd16, 32'h12345678, 4'hF);
    tick(); tick();
    chk("oob_wr_err", {31'h0, wr_err}, 32'h1);
    read_all("after_oob");

    // Cursor overlay blinking every BLINK_DIV cycles, in step with cursor
    do_write(32'd2, 32'h0F0F0F0F, 4'hF);
    tick(); tick();
    cursor_addr = 32'd2; pointer = 32'd2; cursor_en = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      logic exp_cur;
      exp_cur = (((ecnt - 1) / TB_BLINK) % 2) == 0;
      chk($sformatf("cursor_%0d", i), {31'h0, cursor}, {31'h0, exp_cur});
      chk($sformatf("overlay_%0d", i), displayData, exp_cur ? 32'hF0F0F0F0 : 32'h0F0F0F0F);
      tick();
    end
    cursor_en = 1'b0;
    tick(); tick();
    chk("no_overlay_disabled", displayData, 32'h0F0F0F0F);
    chk("wr_err_sticky", {31'h0, wr_err}, 32'h1);

    // Reset mid-clear: fill stops where it was, no fixup
    clear_req = 1'b1; fill_data = 32'h5A5A5A5A;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_ready", {31'h0, wr_ready}, 32'h0);
    chk("midrst_wr_err", {31'h0, wr_err}, 32'h0);
    chk("midrst_display", displayData, 32'h0);
    rst = 1'b0;
    model_err = 1'b0;
    tick();
    chk("post_rst_ready", {31'h0, wr_ready}, 32'h1);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    for (int a = 0; a < 4; a++) model_mem[a] = 32'h5A5A5A5A;
    read_all("partial");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
